// File: rtl/axis_preamble_detector.sv
// ============================================================================
// Module      : axis_preamble_detector
// Description : AXI4-Stream receiver that hunts for the fixed preamble
//               sequence PREAMBLE_BASE, PREAMBLE_BASE+1, ... , drops it and
//               forwards the following payload words with zero latency.
//               Optional macro AXIS_PREAMBLE_DET_STATS_EN enables saturating
//               detect/abort counters on det_count / err_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_preamble_detector #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    PREAMBLE_LEN  = 8,
    parameter logic [DATA_WIDTH-1:0] PREAMBLE_BASE = 1,
    parameter int                    LEN_W         = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [LEN_W-1:0]      cfg_payload_len,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  locked,
    output logic                  preamble_det,
    output logic                  preamble_err,
    output logic [15:0]           det_count,
    output logic [15:0]           err_count
);

    localparam int               IDX_W    = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PREAMBLE_LEN - 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_MATCH   = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [LEN_W-1:0]        cnt;
    logic [LEN_W-1:0]        len_q;

    logic                    in_payload;
    logic                    s_fire;
    logic                    len_hit;
    logic [DATA_WIDTH-1:0]   expected_word;

    // Payload is a pure wire path: the upstream holds data/last/valid stable
    // while stalled, so nothing here can alter a pending beat.
    always_comb begin
        in_payload    = (state == ST_PAYLOAD);
        s_axis_tready = in_payload ? m_axis_tready : 1'b1;
        m_axis_tvalid = in_payload & s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        len_hit       = (len_q != '0) && (cnt == (len_q - LEN_W'(1)));
        m_axis_tlast  = in_payload & (s_axis_tlast | len_hit);
        s_fire        = s_axis_tvalid & s_axis_tready;
        expected_word = PREAMBLE_BASE + DATA_WIDTH'(idx);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state        <= ST_HUNT;
            idx          <= '0;
            cnt          <= '0;
            len_q        <= '0;
            locked       <= 1'b0;
            preamble_det <= 1'b0;
            preamble_err <= 1'b0;
        end else begin
            preamble_det <= 1'b0;
            preamble_err <= 1'b0;
            case (state)
                ST_HUNT: begin
                    if (s_fire && !s_axis_tlast && (s_axis_tdata == PREAMBLE_BASE)) begin
                        idx   <= IDX_W'(1);
                        state <= ST_MATCH;
                    end
                end
                ST_MATCH: begin
                    if (s_fire) begin
                        if (s_axis_tlast) begin
                            state        <= ST_HUNT;
                            idx          <= '0;
                            preamble_err <= 1'b1;
                        end else if (s_axis_tdata == expected_word) begin
                            if (idx == LAST_IDX) begin
                                state        <= ST_PAYLOAD;
                                idx          <= '0;
                                cnt          <= '0;
                                len_q        <= cfg_payload_len;
                                locked       <= 1'b1;
                                preamble_det <= 1'b1;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end else begin
                            // A stray base word may be the start of a fresh preamble.
                            preamble_err <= 1'b1;
                            if (s_axis_tdata == PREAMBLE_BASE) begin
                                idx <= IDX_W'(1);
                            end else begin
                                idx   <= '0;
                                state <= ST_HUNT;
                            end
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (s_fire) begin
                        if (m_axis_tlast) begin
                            state  <= ST_HUNT;
                            cnt    <= '0;
                            locked <= 1'b0;
                        end else begin
                            cnt <= cnt + LEN_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= ST_HUNT;
                    idx    <= '0;
                    cnt    <= '0;
                    locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXIS_PREAMBLE_DET_STATS_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            det_count <= '0;
            err_count <= '0;
        end else begin
            if (preamble_det && (det_count != 16'hFFFF)) begin
                det_count <= det_count + 16'd1;
            end
            if (preamble_err && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`else
    assign det_count = '0;
    assign err_count = '0;
`endif

endmodule

`default_nettype wire

// File: doc/axis_preamble_detector.md
Name: axis_preamble_detector

Overview:
- Receive side of the Preamble link: AXI4-Stream slave that hunts the incoming stream for the fixed preamble sequence emitted by the Preamble generator.
- Discards preamble words, then forwards the following payload words unchanged on an AXI4-Stream master port.
- Sits between the link input and downstream consumers; reports lock and error events as single-cycle pulses.

Parameters:
- DATA_WIDTH, 32, width of tdata on both stream ports.
- PREAMBLE_LEN, 8, number of preamble words; legal range 2..255.
- PREAMBLE_BASE, 1, value of preamble word 0. Preamble word k is PREAMBLE_BASE+k, computed modulo 2^DATA_WIDTH.
- LEN_W, 16, width of the payload length configuration and the payload counter.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  reset, asynchronous, active-low.
- cfg_payload_len  in  LEN_W  payload words per frame; 0 = forward until input tlast. Sampled on entry to PAYLOAD.
- s_axis_tdata  in  DATA_WIDTH  input stream data.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end of packet.
- m_axis_tdata  out  DATA_WIDTH  payload data.
- m_axis_tvalid  out  1  payload valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last payload word of frame.
- locked  out  1  high while in PAYLOAD.
- preamble_det  out  1  one-cycle pulse on preamble completion.
- preamble_err  out  1  one-cycle pulse on partial-preamble abort.
- det_count  out  16  frames detected (optional feature).
- err_count  out  16  aborts (optional feature).

Behaviour:
- Reset values: state HUNT, idx 0, payload counter 0, locked 0, preamble_det 0, preamble_err 0, m_axis_tvalid 0, det_count 0, err_count 0. Reset may assert at any cycle, including mid-frame; it returns the block to HUNT immediately and produces no pulses.
- Handshake: a beat transfers when tvalid&tready are both high at a rising edge. Data, last and valid are never changed by this block while a beat is pending.
- HUNT:
  - s_axis_tready=1; m_axis_tvalid=0.
  - A beat with tdata==PREAMBLE_BASE and tlast=0 sets idx=1 and moves to MATCH.
  - Any other beat is dropped.
- MATCH:
  - s_axis_tready=1; m_axis_tvalid=0.
  - Beat equal to PREAMBLE_BASE+idx with tlast=0:
    - If idx==PREAMBLE_LEN-1: go to PAYLOAD, load payload counter with 0, latch cfg_payload_len, and pulse preamble_det on the next cycle.
    - Otherwise: idx increments.
  - Mismatched beat (no tlast):
    - If tdata==PREAMBLE_BASE: idx=1 and stay in MATCH (resync).
    - Otherwise: go to HUNT.
    - In both cases pulse preamble_err.
  - Beat with tlast=1 in MATCH (matching or not): go to HUNT, pulse preamble_err.
- PAYLOAD:
  - Combinational pass-through: m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready. Zero latency.
  - Each transferred beat increments the payload counter.
  - m_axis_tlast = s_axis_tlast OR (latched len != 0 AND counter == len-1).
  - A transfer with m_axis_tlast=1 returns the block to HUNT, clears locked, and clears the counter. Input tlast arriving before len is reached ends the frame early, with no error.
  - When latched len != 0, the counter never exceeds len-1.
- locked equals (state==PAYLOAD), registered.
- Preamble words are never forwarded; the output carries only payload.
- If PREAMBLE_BASE+k wraps past 2^DATA_WIDTH-1, it compares modulo 2^DATA_WIDTH.

Optional Feature:
- Macro AXIS_PREAMBLE_DET_STATS_EN.
- When defined: det_count increments on each preamble_det pulse and err_count on each preamble_err pulse. Both are 16-bit, saturate at 0xFFFF, and are cleared only by reset.
- When undefined: both ports are tied to 0 and no counter flops are synthesized. All other behaviour is identical.

Test Plan:
- Matched frame: cfg_payload_len=4, m_axis_tready=1; stream 0x01..0x08, then 0xA0,0xA1,0xA2,0xA3. Required: preamble_det pulses once, the cycle after 0x08. Output is exactly 0xA0..0xA3 with tlast on 0xA3. locked is high from the cycle after 0x08 until the cycle after 0xA3.
- Broken preamble with resync: 0x01,0x02,0x01,0x02..0x08, then payload 0xB0 (cfg_payload_len=1). Required: preamble_err pulses once, at the second 0x01. Detection follows; output is 0xB0 with tlast.
- Early tlast: cfg_payload_len=0, preamble, then 0xC0,0xC1 with tlast on 0xC1. Required: output 0xC0,0xC1 with tlast on 0xC1, return to HUNT, no error pulse.
- Backpressure: cfg_payload_len=3, m_axis_tready toggling 1,0,0,1 during payload. Required: s_axis_tready mirrors m_axis_tready. No beat is lost or duplicated; output is 0xD0,0xD1,0xD2 with tlast on 0xD2.
- tlast in preamble: 0x01..0x05 with tlast on 0x05. Required: preamble_err pulses, the block returns to HUNT, and there is no output. A following valid preamble still detects.
- Mid-payload reset, with AXIS_PREAMBLE_DET_STATS_EN defined: two good frames, then ARESETN asserted low after payload word 1 of a third frame. Required: before the reset det_count=2 and err_count=0. On reset m_axis_tvalid=0, locked=0, and both counts=0.
